// File: rtl/uart_echo_dev.sv
// UART virtual device: checks incoming frames, buffers good words in a FIFO and
// retransmits each one (optionally inverted), with saturating error/status counters.
module uart_echo_dev #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int XFORM        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic                          tx_hold_i,
    output logic                          tx_o,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   rx_frame_cnt,
    output logic [7:0]                    parity_err_cnt,
    output logic [7:0]                    frame_err_cnt,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BIT_W = 4;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DAT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic             PODD     = (PARITY_ODD != 0);
    localparam logic             PEN      = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_RECOVER
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [DATA_BITS-1:0] xform(input logic [DATA_BITS-1:0] d);
        return (XFORM != 0) ? ~d : d;
    endfunction

    // ---------------- input synchronizer and edge detect ----------------
    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_prev;
    logic w_rx;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx      = r_rx_s2;
    assign w_rx_fall = r_rx_prev & ~r_rx_s2;

    // ---------------- receive FSM ----------------
    rx_state_t            r_rx_state;
    rx_state_t            w_rx_state_nx;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [CNT_W-1:0]     w_rx_cnt_nx;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [BIT_W-1:0]     w_rx_bit_nx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] w_rx_shift_nx;
    logic                 r_rx_perr;
    logic                 w_rx_perr_nx;
    logic                 r_rx_ferr;
    logic                 w_rx_ferr_nx;
    logic                 w_rx_ferr_now;
    logic                 w_rx_good;
    logic                 w_rx_perr_evt;
    logic                 w_rx_ferr_evt;
    logic                 w_rx_tick;

    assign w_rx_tick = (r_rx_cnt == CNT_LAST);

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_perr_nx  = r_rx_perr;
        w_rx_ferr_nx  = r_rx_ferr;
        w_rx_ferr_now = r_rx_ferr | ~w_rx;
        w_rx_good     = 1'b0;
        w_rx_perr_evt = 1'b0;
        w_rx_ferr_evt = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nx = RX_START;
                    w_rx_cnt_nx   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (r_rx_cnt == CNT_MID) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_perr_nx  = 1'b0;
                    w_rx_ferr_nx  = 1'b0;
                    w_rx_state_nx = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {w_rx, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == DAT_LAST) begin
                        w_rx_bit_nx   = '0;
                        w_rx_state_nx = PEN ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_bit_nx = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_PARITY: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_perr_nx  = ((^r_rx_shift) ^ w_rx) != PODD;
                    w_rx_state_nx = RX_STOP;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nx  = '0;
                    w_rx_ferr_nx = w_rx_ferr_now;
                    if (r_rx_bit == STP_LAST) begin
                        // Framing errors win over parity errors; one counter per frame.
                        w_rx_bit_nx = '0;
                        if (w_rx_ferr_now) begin
                            w_rx_ferr_evt = 1'b1;
                            w_rx_state_nx = RX_RECOVER;
                        end else if (r_rx_perr) begin
                            w_rx_perr_evt = 1'b1;
                            w_rx_state_nx = RX_IDLE;
                        end else begin
                            w_rx_good     = 1'b1;
                            w_rx_state_nx = RX_IDLE;
                        end
                    end else begin
                        w_rx_bit_nx = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_RECOVER: begin
                if (w_rx) begin
                    w_rx_state_nx = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nx = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_perr  <= w_rx_perr_nx;
            r_rx_ferr  <= w_rx_ferr_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_rx_shift <= w_rx_shift_nx;
    end

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_level;
    logic [DATA_BITS-1:0] w_fifo_rd;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf_set;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_fifo_rd = r_mem[r_rptr];
    // A full FIFO still accepts a word when the transmitter pops in the same cycle.
    assign w_push    = w_rx_good & (~w_full | w_pop);
    assign w_ovf_set = w_rx_good & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= xform(r_rx_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- status counters ----------------
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_perr_cnt;
    logic [7:0]  r_ferr_cnt;
    logic        r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_perr_cnt  <= '0;
            r_ferr_cnt  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_rx_good) begin
                r_frame_cnt <= sat_inc16(r_frame_cnt);
            end
            if (w_rx_perr_evt) begin
                r_perr_cnt <= sat_inc8(r_perr_cnt);
            end
            if (w_rx_ferr_evt) begin
                r_ferr_cnt <= sat_inc8(r_ferr_cnt);
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- transmit FSM ----------------
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_state_nx;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [CNT_W-1:0]     w_tx_cnt_nx;
    logic [BIT_W-1:0]     r_tx_bit;
    logic [BIT_W-1:0]     w_tx_bit_nx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 w_tx_shift_en;
    logic                 w_tx_tick;
    logic                 r_tx_o;
    logic                 r_tx_busy;

    assign w_tx_tick = (r_tx_cnt == CNT_LAST);

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_en = 1'b0;
        w_pop         = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty && !tx_hold_i) begin
                    w_pop         = 1'b1;
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_DATA;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_en = 1'b1;
                    if (r_tx_bit == DAT_LAST) begin
                        w_tx_bit_nx   = '0;
                        w_tx_state_nx = PEN ? TX_PARITY : TX_STOP;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_PARITY: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_STOP;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == STP_LAST) begin
                        w_tx_bit_nx   = '0;
                        w_tx_state_nx = TX_IDLE;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_tx_shift <= w_fifo_rd;
            r_tx_par   <= (^w_fifo_rd) ^ PODD;
        end else if (w_tx_shift_en) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    // Line and busy are registered from the FSM state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_o    <= 1'b1;
            r_tx_busy <= 1'b0;
        end else begin
            r_tx_busy <= (r_tx_state != TX_IDLE);
            case (r_tx_state)
                TX_START:  r_tx_o <= 1'b0;
                TX_DATA:   r_tx_o <= r_tx_shift[0];
                TX_PARITY: r_tx_o <= r_tx_par;
                default:   r_tx_o <= 1'b1;
            endcase
        end
    end

    assign tx_o           = r_tx_o;
    assign tx_busy        = r_tx_busy;
    assign fifo_level     = r_level;
    assign rx_frame_cnt   = r_frame_cnt;
    assign parity_err_cnt = r_perr_cnt;
    assign frame_err_cnt  = r_ferr_cnt;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_uart_echo_dev.sv
// Bench for uart_echo_dev: three configurations driven serially, TX frames decoded
// by monitors and compared against a queue of expected words.
module tb_uart_echo_dev;

    localparam int BIT_T = 4;

    logic clk;
    logic rst;
    logic rx_line;
    int   sel;
    logic rx_a, rx_b, rx_c;
    logic hold_a, hold_b, hold_c;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;
    logic [2:0] lvl_a;
    logic [1:0] lvl_b;
    logic [2:0] lvl_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [7:0] perr_a, perr_b, perr_c;
    logic [7:0] ferr_a, ferr_b, ferr_c;
    logic ovf_a, ovf_b, ovf_c;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rst_epoch = 0;
    int p_cyc = 0;
    logic [15:0] last_cnt_a = '0;
    int seen[3] = '{0, 0, 0};
    int fall_last[3] = '{0, 0, 0};
    int fall_prev[3] = '{0, 0, 0};
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];

    assign rx_a = (sel == 0) ? rx_line : 1'b1;
    assign rx_b = (sel == 1) ? rx_line : 1'b1;
    assign rx_c = (sel == 2) ? rx_line : 1'b1;

    uart_echo_dev #(.CLKS_PER_BIT(4)) u_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .tx_hold_i(hold_a), .tx_o(tx_a), .tx_busy(busy_a),
        .fifo_level(lvl_a), .rx_frame_cnt(cnt_a), .parity_err_cnt(perr_a),
        .frame_err_cnt(ferr_a), .overflow(ovf_a)
    );

    uart_echo_dev #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .XFORM(1), .FIFO_DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .rx_i(rx_b), .tx_hold_i(hold_b), .tx_o(tx_b), .tx_busy(busy_b),
        .fifo_level(lvl_b), .rx_frame_cnt(cnt_b), .parity_err_cnt(perr_b),
        .frame_err_cnt(ferr_b), .overflow(ovf_b)
    );

    uart_echo_dev #(.CLKS_PER_BIT(4), .DATA_BITS(9), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx_i(rx_c), .tx_hold_i(hold_c), .tx_o(tx_c), .tx_busy(busy_c),
        .fifo_level(lvl_c), .rx_frame_cnt(cnt_c), .parity_err_cnt(perr_c),
        .frame_err_cnt(ferr_c), .overflow(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_epoch <= rst_epoch + 1;
    end

    // Edge P of instance A is the cycle its good-frame counter moves.
    always @(negedge clk) begin
        if (cnt_a !== last_cnt_a) p_cyc = cyc;
        last_cnt_a = cnt_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int i);
        case (i)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic pop_exp(input int inst, output bit ok, output logic [8:0] e);
        ok = 1'b1;
        e  = '0;
        case (inst)
            0:       if (q_a.size() > 0) e = q_a.pop_front(); else ok = 1'b0;
            1:       if (q_b.size() > 0) e = q_b.pop_front(); else ok = 1'b0;
            default: if (q_c.size() > 0) e = q_c.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic monitor(input int inst, input int nb, input bit pen, input bit podd, input int nstop);
        logic [8:0] d;
        logic [8:0] e;
        logic       st, bsy, pb, par, stop_ok;
        bit         ok;
        int         ep;
        forever begin
            do @(negedge clk); while (tx_of(inst) !== 1'b0);
            fall_prev[inst] = fall_last[inst];
            fall_last[inst] = cyc;
            ep = rst_epoch;
            @(negedge clk);
            st  = tx_of(inst);
            bsy = busy_of(inst);
            d   = '0;
            pb  = 1'b0;
            for (int i = 0; i < nb; i++) begin
                repeat (BIT_T) @(negedge clk);
                d[i] = tx_of(inst);
            end
            if (pen) begin
                repeat (BIT_T) @(negedge clk);
                pb = tx_of(inst);
            end
            stop_ok = 1'b1;
            for (int i = 0; i < nstop; i++) begin
                repeat (BIT_T) @(negedge clk);
                if (tx_of(inst) !== 1'b1) stop_ok = 1'b0;
            end
            if (ep != rst_epoch) continue;
            seen[inst]++;
            pop_exp(inst, ok, e);
            check($sformatf("m%0d_expected_frame", inst), ok, 1);
            if (ok) begin
                check($sformatf("m%0d_data", inst), d, e);
                check($sformatf("m%0d_start", inst), st, 0);
                check($sformatf("m%0d_busy", inst), bsy, 1);
                check($sformatf("m%0d_stop", inst), stop_ok, 1);
                if (pen) begin
                    par = podd;
                    for (int i = 0; i < nb; i++) par = par ^ e[i];
                    check($sformatf("m%0d_parity", inst), pb, par);
                end
            end
        end
    endtask

    initial monitor(0, 8, 1'b0, 1'b0, 1);
    initial monitor(1, 8, 1'b1, 1'b0, 1);
    initial monitor(2, 9, 1'b0, 1'b0, 2);

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int s, input logic [8:0] d, input int nb, input bit pen,
                              input logic pb, input int nstop, input logic stopv);
        sel = s;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (BIT_T) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_line = d[i];
            repeat (BIT_T) @(negedge clk);
        end
        if (pen) begin
            rx_line = pb;
            repeat (BIT_T) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_line = stopv;
            repeat (BIT_T) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic wait_seen(input int inst, input int target, input string tag);
        int n;
        n = 0;
        while (seen[inst] < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, seen[inst], target);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rx_line = 1'b1;
        sel = 0;
        hold_a = 1'b0;
        hold_b = 1'b0;
        hold_c = 1'b0;
        idle(3);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_level", lvl_a, 0);
        check("rst_frames", cnt_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        idle(4);

        // Plain echo of 0xA5 with latency from edge P to the TX start bit.
        q_a.push_back(9'h0A5);
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_seen(0, 1, "a_a5_seen");
        check("a_a5_frames", cnt_a, 1);
        check("a_p_to_fall", fall_last[0] - p_cyc, 2);
        check("a_a5_level", lvl_a, 0);
        idle(8);

        // Inverting transform with even parity.
        q_b.push_back(9'h0C3);
        send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
        wait_seen(1, 1, "b_3c_seen");
        check("b_3c_frames", cnt_b, 1);
        check("b_3c_perr", perr_b, 0);
        check("b_3c_ferr", ferr_b, 0);
        idle(8);

        // Parity error: frame dropped, nothing transmitted.
        send_frame(1, 9'h001, 8, 1'b1, 1'b0, 1, 1'b1);
        idle(20);
        check("b_perr_cnt", perr_b, 1);
        check("b_perr_level", lvl_b, 0);
        check("b_perr_tx", tx_b, 1);
        check("b_perr_seen", seen[1], 1);
        check("b_perr_frames", cnt_b, 1);

        // Framing error with the line held low for three bit times, then recovery.
        send_frame(1, 9'h055, 8, 1'b1, 1'b0, 1, 1'b0);
        rx_line = 1'b0;
        idle(2 * BIT_T);
        rx_line = 1'b1;
        idle(8);
        check("b_ferr_cnt", ferr_b, 1);
        check("b_ferr_perr", perr_b, 1);
        check("b_ferr_frames", cnt_b, 1);
        q_b.push_back(9'h0AA);
        send_frame(1, 9'h055, 8, 1'b1, 1'b0, 1, 1'b1);
        wait_seen(1, 2, "b_55_seen");
        check("b_55_frames", cnt_b, 2);
        idle(8);

        // Overflow: depth-2 FIFO held, third frame dropped, then drained back-to-back.
        hold_b = 1'b1;
        q_b.push_back(9'h0EE);
        send_frame(1, 9'h011, 8, 1'b1, 1'b0, 1, 1'b1);
        idle(4);
        q_b.push_back(9'h0DD);
        send_frame(1, 9'h022, 8, 1'b1, 1'b0, 1, 1'b1);
        idle(4);
        send_frame(1, 9'h033, 8, 1'b1, 1'b0, 1, 1'b1);
        idle(8);
        check("b_ovf_level", lvl_b, 2);
        check("b_ovf_flag", ovf_b, 1);
        check("b_ovf_frames", cnt_b, 5);
        check("b_ovf_held", seen[1], 2);
        hold_b = 1'b0;
        wait_seen(1, 4, "b_drain_seen");
        check("b_drain_gap", fall_last[1] - fall_prev[1], 11 * BIT_T + 1);
        idle(10);
        check("b_drain_level", lvl_b, 0);

        // One-cycle glitch is ignored; then a 9-bit, two-stop-bit frame.
        sel = 2;
        @(negedge clk);
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        idle(12);
        check("c_glitch_frames", cnt_c, 0);
        check("c_glitch_perr", perr_c, 0);
        check("c_glitch_ferr", ferr_c, 0);
        check("c_glitch_level", lvl_c, 0);
        q_c.push_back(9'h1A5);
        send_frame(2, 9'h1A5, 9, 1'b0, 1'b0, 2, 1'b1);
        wait_seen(2, 1, "c_1a5_seen");
        check("c_1a5_frames", cnt_c, 1);
        idle(8);

        // Reset in the middle of transmitting 0xFF.
        send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
        n = 0;
        while (busy_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_busy_before_rst", busy_a, 1);
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        check("a_rst_tx", tx_a, 1);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_level", lvl_a, 0);
        check("a_rst_frames", cnt_a, 0);
        check("b_rst_ovf", ovf_b, 0);
        check("b_rst_perr", perr_b, 0);
        rst = 1'b0;
        idle(60);
        q_a.push_back(9'h05A);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_seen(0, 2, "a_5a_seen");
        check("a_5a_frames", cnt_a, 1);
        idle(8);

        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        check("q_c_drained", q_c.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
